// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side issues start and the operands. The slave side returns status and results.
interface serial_subtractor_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [N-1:0] D;
    logic         Bout;
    logic         ovf;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout, ovf
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B - Bin, processed one bit per clock through a single full-subtractor cell.
// Reports the difference, borrow-out and signed overflow, with a one-cycle done pulse.
module serial_subtractor #(
    parameter int N = 4
) (
    input logic               clk,
    input logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t       state_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [N-1:0] dsr_q;
    logic         br_q;
    logic [CW-1:0] cnt_q;

    logic         busy_q;
    logic         done_q;
    logic [N-1:0] d_q;
    logic         bout_q;
    logic         ovf_q;

    logic         a_bit;
    logic         b_bit;
    logic         d_bit;
    logic         br_d;
    logic [N-1:0] dsr_d;
    logic         last_bit;

    always_comb begin
        a_bit    = a_q[0];
        b_bit    = b_q[0];
        d_bit    = a_bit ^ b_bit ^ br_q;
        br_d     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        // Difference bits enter at the MSB end, so after N shifts bit 0 holds the first-computed LSB.
        dsr_d    = {d_bit, dsr_q[N-1:1]};
        last_bit = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dsr_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        br_q    <= bus.Bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    dsr_q <= dsr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // On the MSB, br_q is the borrow into the MSB, so XOR with the borrow out gives overflow.
                        d_q     <= dsr_d;
                        bout_q  <= br_d;
                        ovf_q   <= br_q ^ br_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at N=4 and N=8.
// Expected values come from hand-computed vectors and an integer model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.N(4)) if4 ();
    serial_subtractor_if #(.N(8)) if8 ();

    serial_subtractor #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_subtractor #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b, input logic bin);
        if (w == 4) begin
            if4.start = s; if4.A = a[3:0]; if4.B = b[3:0]; if4.Bin = bin;
        end else begin
            if8.start = s; if8.A = a; if8.B = b; if8.Bin = bin;
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 4) ? if4.done : if8.done;
    endfunction

    // Call at #1 after an edge while the DUT is in IDLE or DONE. Returns at #1 after the done edge.
    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output logic [7:0] d, output logic bout, output logic ovf, output int lat);
        drive(w, 1'b1, a, b, bin);
        @(posedge clk); #1;
        drive(w, 1'b0, a, b, bin);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (get_done(w)) begin
                lat = c;
                break;
            end
        end
        if (w == 4) begin
            d = {4'd0, if4.D}; bout = if4.Bout; ovf = if4.ovf;
        end else begin
            d = if8.D; bout = if8.Bout; ovf = if8.ovf;
        end
    endtask

    function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                                  output logic [7:0] d, output logic bout, output logic ovf);
        int full, ua, ub, sa, sb, diff, sd;
        full = 1 << w;
        ua   = int'(a);
        ub   = int'(b);
        diff = ua - ub - int'(bin);
        d    = 8'((diff + 2 * full) % full);
        bout = (ua < ub + int'(bin));
        sa   = (ua >= full / 2) ? ua - full : ua;
        sb   = (ub >= full / 2) ? ub - full : ub;
        sd   = sa - sb - int'(bin);
        ovf  = (sd < -(full / 2)) || (sd > full / 2 - 1);
    endfunction

    initial begin
        logic [7:0] d, ed, ra, rb;
        logic       bout, ovf, eb, eo, rbin;
        int         lat, c, ndone, last_t, first_t;

        vecs[0] = '{4'd7,  4'd3,  1'b0, 4'd4,  1'b0, 1'b0};
        vecs[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0};
        vecs[2] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
        vecs[3] = '{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1};
        vecs[4] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
        vecs[5] = '{4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b0};
        vecs[6] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0, 1'b0};
        vecs[7] = '{4'd8,  4'd0,  1'b1, 4'd7,  1'b0, 1'b1};

        drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(if4.busy), 32'd0);
        chk("rst_done", 32'(if4.done), 32'd0);
        chk("rst_D",    32'(if4.D),    32'd0);
        chk("rst_Bout", 32'(if4.Bout), 32'd0);
        chk("rst_ovf",  32'(if4.ovf),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(4, {4'd0, vecs[i].a}, {4'd0, vecs[i].b}, vecs[i].bin, d, bout, ovf, lat);
            chk($sformatf("vec%0d_D", i),    32'(d),    32'(vecs[i].d));
            chk($sformatf("vec%0d_Bout", i), 32'(bout), 32'(vecs[i].bout));
            chk($sformatf("vec%0d_ovf", i),  32'(ovf),  32'(vecs[i].ovf));
            chk($sformatf("vec%0d_lat", i),  32'(lat),  32'd4);
        end

        // Reset in the middle of an operation.
        drive(4, 1'b1, 8'd7, 8'd3, 1'b0);
        @(posedge clk); #1;
        drive(4, 1'b0, 8'd7, 8'd3, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(if4.busy), 32'd0);
        chk("midrst_done", 32'(if4.done), 32'd0);
        chk("midrst_D",    32'(if4.D),    32'd0);
        chk("midrst_Bout", 32'(if4.Bout), 32'd0);
        chk("midrst_ovf",  32'(if4.ovf),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin @(posedge clk); #1; if (if4.done) ndone++; end
        chk("midrst_nodone", 32'(ndone), 32'd0);
        run_op(4, 8'd7, 8'd3, 1'b0, d, bout, ovf, lat);
        chk("after_rst_D",   32'(d),    32'd4);
        chk("after_rst_B",   32'(bout), 32'd0);
        chk("after_rst_ovf", 32'(ovf),  32'd0);
        chk("after_rst_lat", 32'(lat),  32'd4);

        // A start pulse while busy must be ignored.
        drive(4, 1'b1, 8'd3, 8'd5, 1'b0);
        @(posedge clk); #1;
        drive(4, 1'b0, 8'd3, 8'd5, 1'b0);
        lat = -1;
        for (c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 2) drive(4, 1'b1, 8'd0, 8'd0, 1'b1);
            if (c == 3) drive(4, 1'b0, 8'd0, 8'd0, 1'b1);
            if (if4.done) begin lat = c; break; end
        end
        chk("ign_lat",  32'(lat),       32'd4);
        chk("ign_D",    32'(if4.D),     32'd14);
        chk("ign_Bout", 32'(if4.Bout),  32'd1);
        chk("ign_ovf",  32'(if4.ovf),   32'd0);
        ndone = 0;
        repeat (8) begin @(posedge clk); #1; if (if4.done || if4.busy) ndone++; end
        chk("ign_noextra", 32'(ndone), 32'd0);

        // Start held high: back-to-back results every N+1 cycles.
        drive(4, 1'b1, 8'd7, 8'd3, 1'b0);
        ndone = 0; last_t = 0; first_t = 0;
        for (c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            if (if4.done) begin
                ndone++;
                if (first_t == 0) first_t = c;
                else chk("b2b_period", 32'(c - last_t), 32'd5);
                last_t = c;
            end
            if (first_t != 0) chk("b2b_D_stable", 32'(if4.D), 32'd4);
        end
        chk("b2b_first", 32'(first_t), 32'd5);
        chk("b2b_count", 32'(ndone),   32'd5);
        drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (6) begin @(posedge clk); #1; end

        // Random regression against the integer model at both widths.
        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom) & 8'h0F; rb = 8'($urandom) & 8'h0F; rbin = 1'($urandom);
            model(4, ra, rb, rbin, ed, eb, eo);
            run_op(4, ra, rb, rbin, d, bout, ovf, lat);
            chk($sformatf("rand4 a=%0d b=%0d bin=%0d {D,Bout,ovf,lat}", ra, rb, rbin),
                32'({d, bout, ovf, 8'(lat)}), 32'({ed, eb, eo, 8'd4}));
        end
        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            model(8, ra, rb, rbin, ed, eb, eo);
            run_op(8, ra, rb, rbin, d, bout, ovf, lat);
            chk($sformatf("rand8 a=%0d b=%0d bin=%0d {D,Bout,ovf,lat}", ra, rb, rbin),
                32'({d, bout, ovf, 8'(lat)}), 32'({ed, eb, eo, 8'd8}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor, the inverse of the team's ripple-carry adder datapath. Computes D = A − B − Bin one bit per clock through a single full-subtractor cell. Latches operands on a start handshake and reports difference, borrow-out and signed overflow with a one-cycle done pulse. Used where area matters more than latency, and as a sequential building block for later divider/ALU work.

Parameters:
N, 4, operand/result width in bits (N ≥ 2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy=0
A  input  N  minuend, sampled at the accepting edge
B  input  N  subtrahend, sampled at the accepting edge
Bin  input  1  borrow-in, sampled at the accepting edge
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; results valid
D  output  N  difference, LSB first internally, presented parallel
Bout  output  1  borrow out of MSB (unsigned A < B+Bin)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low, async, any state): state=IDLE; busy=0, done=0, D=0, Bout=0, ovf=0; operand shift regs, borrow reg and bit counter cleared. Any in-flight operation is aborted with no done.
- States: IDLE, BUSY, DONE.
- IDLE/DONE, start=1 at edge k: latch A, B into shift regs; borrow reg=Bin; counter=0; go BUSY; busy=1 from edge k. Other outputs unchanged until completion.
- IDLE/DONE, start=0: DONE→IDLE at the next edge (done clears); IDLE holds.
- BUSY, edges k+1..k+N: bit i=counter.
  - d = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - Shift d into the D shift reg from the MSB end; update br; counter++.
  - start is ignored while busy=1.
- Edge k+N (last bit): go DONE. D, Bout=br', and ovf update in the same edge. ovf = (borrow into MSB) XOR (borrow out of MSB). Set done=1, busy=0.
- Latency: start edge → done high exactly N cycles later. done is high for exactly one cycle unless a new start is accepted in DONE (back-to-back).
- D, Bout, ovf hold their values until the next completion or reset. They do not change during a subsequent BUSY phase; use internal shift regs, not the output regs.
- Back-to-back: start accepted in DONE goes directly to BUSY, so throughput is one result per N+1 cycles.
- Arithmetic: D = (A − B − Bin) mod 2^N. Bout=1 iff A < B + Bin (unsigned).
- Counter is ceil(log2(N+1)) bits wide and must not wrap before N.

Test Plan:
- N=4, reset mid-BUSY: start with A=7, B=3, then drop rst_n after 2 cycles → all outputs 0 immediately, state IDLE, no done. Then A=7, B=3, Bin=0 → done exactly 4 cycles after the start edge, D=4, Bout=0, ovf=0.
- A=3, B=5, Bin=0 → D=14 (1110), Bout=1, ovf=0.
- A=8 (−8), B=1, Bin=0 → D=7, Bout=0, ovf=1; and A=7, B=15 (−1), Bin=0 → D=8, Bout=1, ovf=1.
- A=0, B=0, Bin=1 → D=15, Bout=1, ovf=0 (borrow ripples through all bits).
- start pulsed again during BUSY with different operands → ignored; first result is unaffected. start held high continuously → done pulses every 5 cycles, D/Bout/ovf stable between pulses.
- Randomised regression, N=4 and N=8, ≥1000 operations against a reference model of A−B−Bin: D, Bout and ovf match exactly; latency is always N.
